// File: rtl/ha_carry_resolver_pkg.sv
// ----------------------------------------------------------------------------
// ha_carry_resolver_pkg
//   Shared definitions for the half-adder carry resolver.
//   - DEFAULT_W     : default operand width (matches the upstream array)
//   - DEFAULT_CNT_W : default iteration counter width, >= $clog2(W+1)
//   - state_t       : resolver FSM states
// ----------------------------------------------------------------------------
package ha_carry_resolver_pkg;

    localparam int DEFAULT_W     = 4;
    localparam int DEFAULT_CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RESOLVE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/ha_carry_resolver_row.sv
// ----------------------------------------------------------------------------
// ha_carry_resolver_row
//   One combinational half-add row over W+1 bits. Each call moves every
//   pending carry one position to the left and folds it into the sum.
// Ports
//   i_s  in  W+1  current partial sum
//   i_c  in  W+1  current pending carries
//   o_s  out W+1  next partial sum   (i_s ^ i_c)
//   o_c  out W+1  next carries       ((i_s & i_c) << 1, MSB carry dropped)
// ----------------------------------------------------------------------------
module ha_carry_resolver_row
    import ha_carry_resolver_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic [W:0] i_s,
    input  logic [W:0] i_c,
    output logic [W:0] o_s,
    output logic [W:0] o_c
);

    // The sum absorbs the carries bitwise; wherever both were set a new
    // carry is generated one bit higher. The top bit's generated carry would
    // land outside the W+1-bit field, so only the low W bits are ANDed.
    assign o_s = i_s ^ i_c;
    assign o_c = {i_s[W-1:0] & i_c[W-1:0], 1'b0};

endmodule

// File: rtl/ha_carry_resolver.sv
// ----------------------------------------------------------------------------
// ha_carry_resolver
//   Downstream stage of the W-bit half-adder array. Takes the per-bit sum
//   (a^b) and carry (a&b) vectors and repeatedly applies a half-add row until
//   no carries remain, producing the full a+b and the number of rows used.
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      sum_in/carry_in valid
//   in_ready   out  1      block can accept an operand pair (IDLE only)
//   sum_in     in   W      per-bit a^b
//   carry_in   in   W      per-bit a&b
//   out_valid  out  1      result/iters valid
//   out_ready  in   1      consumer accepts the result
//   result     out  W+1    resolved a+b including carry-out
//   iters      out  CNT_W  number of resolve rows that updated s/c
// ----------------------------------------------------------------------------
module ha_carry_resolver
    import ha_carry_resolver_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     sum_in,
    input  logic [W-1:0]     carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W:0]       result,
    output logic [CNT_W-1:0] iters
);

    state_t           r_state;
    logic [W:0]       r_s;
    logic [W:0]       r_c;
    logic [CNT_W-1:0] r_cnt;
    logic             r_inReady;
    logic             r_outValid;
    logic [W:0]       r_result;
    logic [CNT_W-1:0] r_iters;

    logic [W:0]       w_sNxt;
    logic [W:0]       w_cNxt;
    logic             w_resolveDone;
    logic             w_accept;

    // The combinational half-add row; the FSM decides when its outputs are
    // written back into s/c.
    ha_carry_resolver_row #(
        .W (W)
    ) u_row (
        .i_s (r_s),
        .i_c (r_c),
        .o_s (w_sNxt),
        .o_c (w_cNxt)
    );

    // Resolution stops once the carries are gone. The count limit is a
    // safety net: legal inputs never need more than W rows, but a corrupted
    // carry vector must not be able to keep the block busy forever.
    assign w_resolveDone = (r_c == '0) || (r_cnt == CNT_W'(W));

    // The handshake uses the registered ready so the accept edge is exactly
    // the edge the producer sees ready high.
    assign w_accept = r_inReady && in_valid;

    // Single FSM block holding the datapath registers and all registered
    // outputs. in_ready comes up one edge after reset release, and DONE
    // spends one edge loading out_valid before it can hand off the result,
    // which gives the fixed k+2 edge latency from accept to out_valid.
    // result/iters only change on the RESOLVE->DONE edge so the consumer
    // sees them stable for the whole time out_valid is high, and they keep
    // their value afterwards until the next transaction completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_s        <= '0;
            r_c        <= '0;
            r_cnt      <= '0;
            r_inReady  <= 1'b0;
            r_outValid <= 1'b0;
            r_result   <= '0;
            r_iters    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_s       <= {1'b0, sum_in};
                        r_c       <= {carry_in, 1'b0};
                        r_cnt     <= '0;
                        r_inReady <= 1'b0;
                        r_state   <= S_RESOLVE;
                    end else begin
                        r_inReady <= 1'b1;
                    end
                end
                S_RESOLVE: begin
                    if (w_resolveDone) begin
                        r_result <= r_s;
                        r_iters  <= r_cnt;
                        r_state  <= S_DONE;
                    end else begin
                        r_s   <= w_sNxt;
                        r_c   <= w_cNxt;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!r_outValid) begin
                        r_outValid <= 1'b1;
                    end else if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_outValid <= 1'b0;
                    r_inReady  <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign result    = r_result;
    assign iters     = r_iters;

endmodule

// File: tb/tb_ha_carry_resolver.sv
// ----------------------------------------------------------------------------
// tb_ha_carry_resolver
//   Self-checking bench for ha_carry_resolver. Operand pairs are pushed
//   through a behavioural half-adder array (sum=a^b, carry=a&b); expected
//   results come from plain addition and an integer model of the carry
//   resolution loop.
// ----------------------------------------------------------------------------
module tb_ha_carry_resolver;

    localparam int W     = 4;
    localparam int CNT_W = 3;

    typedef struct {
        int res;
        int k;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     sum_in;
    logic [W-1:0]     carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [W:0]       result;
    logic [CNT_W-1:0] iters;

    int   checks   = 0;
    int   failures = 0;
    exp_t expQ[$];

    ha_carry_resolver #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .iters     (iters)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and report it if the values differ.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Integer model: a+b is the answer; the row count is how many times the
    // rule s'=s^c, c'=(s&c)<<1 (W+1 bits) must be applied until c is zero.
    function automatic void modelAdd(input int a, input int b,
                                     output int res, output int k);
        int s;
        int c;
        int t;
        int mask;
        mask = (1 << (W + 1)) - 1;
        s = a ^ b;
        c = ((a & b) << 1) & mask;
        k = 0;
        while (c != 0 && k < 16) begin
            t = s ^ c;
            c = ((s & c) << 1) & mask;
            s = t;
            k++;
        end
        res = s;
    endfunction

    // Compare process: every negedge the result is presented, it must match
    // the oldest outstanding expectation, and ready must stay low.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                checkOutput("cmp_result", 32'(result), 32'(expQ[0].res));
                checkOutput("cmp_iters", 32'(iters), 32'(expQ[0].k));
                checkOutput("cmp_in_ready_busy", 32'(in_ready), 32'd0);
                if (out_ready) expQ.pop_front();
            end
        end
    end

    // Drive one operand pair through the half-adder array, check the accept
    // to out_valid latency, optionally stall the consumer (with ignored
    // in_valid pulses), then complete the handshake.
    task automatic applyStimulus(input int a, input int b, input int stall,
                                 input bit pulse);
        int res;
        int k;
        int edges;
        modelAdd(a, b, res, k);
        checkOutput("model_sum", 32'(res), 32'(a + b));
        @(posedge clk); #1;
        sum_in    = 4'(a ^ b);
        carry_in  = 4'(a & b);
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        edges = 0;
        @(negedge clk);
        while (!in_ready && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 32'(in_ready), 32'd1);
            in_valid  = 1'b0;
            out_ready = 1'b0;
            return;
        end
        expQ.push_back('{res: a + b, k: k});
        @(posedge clk); #1;
        in_valid = 1'b0;
        sum_in   = 4'($urandom);
        carry_in = 4'($urandom);
        edges = 0;
        @(negedge clk);
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        checkOutput("latency", edges, k + 2);
        if (!out_valid) begin
            expQ.delete();
            out_ready = 1'b0;
            return;
        end
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                if (pulse) begin
                    in_valid = i[0];
                    sum_in   = 4'($urandom);
                    carry_in = 4'($urandom);
                end
                @(negedge clk);
                checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
            end
            @(posedge clk); #1;
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("post_out_valid", 32'(out_valid), 32'd0);
        checkOutput("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int pr;
        int pk;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sum_in    = '0;
        carry_in  = '0;

        // Hand-computed pins on the model itself.
        modelAdd(3, 1, pr, pk);
        checkOutput("pin_3p1_k", pk, 2);
        modelAdd(15, 1, pr, pk);
        checkOutput("pin_15p1_k", pk, 4);
        modelAdd(15, 15, pr, pk);
        checkOutput("pin_15p15_k", pk, 1);
        modelAdd(0, 0, pr, pk);
        checkOutput("pin_0p0_k", pk, 0);

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_result", 32'(result), 32'd0);
        checkOutput("rst_iters", 32'(iters), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rel_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] 0+0");
        applyStimulus(0, 0, 0, 1'b0);
        checkOutput("t3_result", 32'(result), 32'd0);
        checkOutput("t3_iters", 32'(iters), 32'd0);

        $display("[TB] 3+1");
        applyStimulus(3, 1, 0, 1'b0);
        checkOutput("t2_result", 32'(result), 32'd4);
        checkOutput("t2_iters", 32'(iters), 32'd2);

        $display("[TB] reset mid-resolve");
        @(posedge clk); #1;
        sum_in   = 4'b1110;
        carry_in = 4'b0001;
        in_valid = 1'b1;
        @(negedge clk);
        checkOutput("mid_pre_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_in_ready", 32'(in_ready), 32'd0);
        checkOutput("mid_result", 32'(result), 32'd0);
        checkOutput("mid_iters", 32'(iters), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid_rel_in_ready", 32'(in_ready), 32'd1);
        checkOutput("mid_rel_out_valid", 32'(out_valid), 32'd0);

        $display("[TB] worst case and wide carries");
        applyStimulus(15, 1, 0, 1'b0);
        checkOutput("t4a_result", 32'(result), 32'd16);
        checkOutput("t4a_iters", 32'(iters), 32'd4);
        applyStimulus(15, 15, 2, 1'b0);
        checkOutput("t4b_result", 32'(result), 32'd30);
        checkOutput("t4b_iters", 32'(iters), 32'd1);

        $display("[TB] back-pressure with in_valid pulses");
        applyStimulus(7, 5, 10, 1'b1);
        checkOutput("t5_result", 32'(result), 32'd12);
        checkOutput("t5_iters", 32'(iters), 32'd2);

        $display("[TB] exhaustive sweep");
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                applyStimulus(a, b, int'($urandom_range(0, 3)), 1'b0);
                checkOutput("iters_bound", 32'(iters <= CNT_W'(W)), 32'd1);
            end
        end

        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
